// File: rtl/system.sv
// Binary 16-bit processor top: boot loader, word-addressed RAM and a
// multi-cycle CPU. A start pulse copies a fixed program image into RAM, then
// the CPU runs it from address 0 until it fetches HALT.

// Eight 16-bit registers; r0 is an ordinary register.
module system_regs (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [2:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [2:0]  raddr_a_i,
  input  logic [2:0]  raddr_b_i,
  input  logic [2:0]  raddr_c_i,
  output logic [15:0] rdata_a_o,
  output logic [15:0] rdata_b_o,
  output logic [15:0] rdata_c_o
);
  logic [15:0] regs [0:7];

  // Register write port; the whole file is cleared on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else if (we_i) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs[raddr_a_i];
  assign rdata_b_o = regs[raddr_b_i];
  assign rdata_c_o = regs[raddr_c_i];
endmodule

// Single-port RAM: asynchronous read, synchronous write, never cleared.
module system_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);
  logic [15:0] memory [0:DEPTH-1];

  // Word write on the rising edge
  always_ff @(posedge clk_i) begin
    if (we_i) memory[addr_i] <= wdata_i;
  end

  assign rdata_o = memory[addr_i];
endmodule

// Boot loader: writes one image word per cycle while enabled.
module system_loader #(
  parameter int PROG_LEN = 7,
  parameter int AW       = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic          mem_write_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [15:0]   mem_write_data_o,
  output logic          last_o
);
  localparam int LW = (PROG_LEN > 1) ? $clog2(PROG_LEN) : 1;

  logic [LW-1:0] address_q, address_d;

  function automatic logic [15:0] image_word(input logic [LW-1:0] k);
    case (k)
      LW'(0):  image_word = 16'h7205;  // LDI   r1,5
      LW'(1):  image_word = 16'h7407;  // LDI   r2,7
      LW'(2):  image_word = 16'h1650;  // ADD   r3,r1,r2
      LW'(3):  image_word = 16'h2888;  // SUB   r4,r2,r1
      LW'(4):  image_word = 16'h9610;  // STORE r3,[r0+16]
      LW'(5):  image_word = 16'h8A10;  // LOAD  r5,[r0+16]
      default: image_word = 16'h0000;  // HALT
    endcase
  endfunction

  assign last_o           = en_i && (address_q == LW'(PROG_LEN - 1));
  assign mem_write_o      = en_i;
  assign mem_addr_o       = AW'(address_q);
  assign mem_write_data_o = image_word(address_q);

  // Next word index; wraps back to 0 after the last word
  always_comb begin
    address_d = address_q;
    if (en_i) begin
      if (last_o) address_d = '0;
      else        address_d = address_q + 1'b1;
    end else begin
      address_d = address_q;
    end
  end

  // Word index register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) address_q <= '0;
    else         address_q <= address_d;
  end
endmodule

// Multi-cycle CPU: FETCH -> EXECUTE -> WRITEBACK, frozen while run_i is low.
module system_cpu #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          run_i,
  input  logic [15:0]   mem_rdata_i,
  output logic          mem_write_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [15:0]   mem_write_data_o
);
  typedef enum logic [1:0] {FETCH = 2'd0, EXECUTE = 2'd1, WRITEBACK = 2'd2} cpu_state_e;

  localparam logic [3:0]  OP_HALT = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
  localparam logic [3:0]  OP_OR = 4'h4, OP_XOR = 4'h5, OP_ADDI = 4'h6, OP_LDI = 4'h7;
  localparam logic [3:0]  OP_LOAD = 4'h8, OP_STORE = 4'h9, OP_BEQ = 4'hA, OP_JMP = 4'hB;
  localparam logic [15:0] PC_MASK = 16'(MEM_DEPTH - 1);

  cpu_state_e  state, state_d;
  logic [15:0] program_counter, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] alu_out_q, alu_out_d;

  logic [3:0]    op_s;
  logic [15:0]   sext_s, rd_val_s, rs1_val_s, rs2_val_s, alu_s, pc_raw_s;
  logic [AW-1:0] ea_s;
  logic          writes_rd_s, rf_we_s;

  assign op_s        = ir_q[15:12];
  assign sext_s      = {{10{ir_q[5]}}, ir_q[5:0]};
  assign ea_s        = rs1_val_s[AW-1:0] + sext_s[AW-1:0];
  assign writes_rd_s = (op_s >= OP_ADD) && (op_s <= OP_LOAD);
  assign mem_write_data_o = rd_val_s;

  system_regs regs (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (rf_we_s),
    .waddr_i   (ir_q[11:9]),
    .wdata_i   (alu_out_q),
    .raddr_a_i (ir_q[11:9]),
    .raddr_b_i (ir_q[8:6]),
    .raddr_c_i (ir_q[5:3]),
    .rdata_a_o (rd_val_s),
    .rdata_b_o (rs1_val_s),
    .rdata_c_o (rs2_val_s)
  );

  // ALU result for the instruction held in ir
  always_comb begin
    alu_s = 16'h0000;
    case (op_s)
      OP_ADD:  alu_s = rs1_val_s + rs2_val_s;
      OP_SUB:  alu_s = rs1_val_s - rs2_val_s;
      OP_AND:  alu_s = rs1_val_s & rs2_val_s;
      OP_OR:   alu_s = rs1_val_s | rs2_val_s;
      OP_XOR:  alu_s = rs1_val_s ^ rs2_val_s;
      OP_ADDI: alu_s = rs1_val_s + sext_s;
      OP_LDI:  alu_s = {7'b0000000, ir_q[8:0]};
      OP_LOAD: alu_s = mem_rdata_i;
      default: alu_s = 16'h0000;
    endcase
  end

  // Next PC before wrapping to the RAM size
  always_comb begin
    pc_raw_s = program_counter + 16'h0001;
    if (op_s == OP_BEQ) begin
      if (rd_val_s == rs1_val_s) pc_raw_s = program_counter + 16'h0001 + sext_s;
      else                       pc_raw_s = program_counter + 16'h0001;
    end else if (op_s == OP_JMP) begin
      pc_raw_s = {4'h0, ir_q[11:0]};
    end else begin
      pc_raw_s = program_counter + 16'h0001;
    end
  end

  // Sequencer next state and memory/register-file controls
  always_comb begin
    state_d     = state;
    pc_d        = program_counter;
    ir_d        = ir_q;
    alu_out_d   = alu_out_q;
    mem_write_o = 1'b0;
    mem_addr_o  = program_counter[AW-1:0];
    rf_we_s     = 1'b0;
    if (run_i) begin
      case (state)
        FETCH: begin
          ir_d = mem_rdata_i;
          if (mem_rdata_i[15:12] == OP_HALT) state_d = FETCH;
          else                               state_d = EXECUTE;
        end
        EXECUTE: begin
          mem_addr_o  = ea_s;
          alu_out_d   = alu_s;
          mem_write_o = (op_s == OP_STORE);
          state_d     = WRITEBACK;
        end
        WRITEBACK: begin
          rf_we_s = writes_rd_s;
          pc_d    = pc_raw_s & PC_MASK;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end else begin
      state_d = FETCH;
      pc_d    = 16'h0000;
    end
  end

  // CPU state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= FETCH;
      program_counter <= 16'h0000;
      ir_q            <= 16'h0000;
      alu_out_q       <= 16'h0000;
    end else begin
      state           <= state_d;
      program_counter <= pc_d;
      ir_q            <= ir_d;
      alu_out_q       <= alu_out_d;
    end
  end
endmodule

module system #(
  parameter int MEM_DEPTH = 256,
  parameter int PROG_LEN  = 7
) (
  input logic clock,
  input logic reset,
  input logic start
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOADING = 2'd1, EXECUTING = 2'd2} sys_state_e;

  sys_state_e system_state, system_state_d;

  logic          ld_write_s, ld_last_s, cpu_write_s;
  logic [AW-1:0] ld_addr_s, cpu_addr_s;
  logic [15:0]   ld_data_s, cpu_data_s, mem_rdata_s;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_write_data;

  system_loader #(.PROG_LEN(PROG_LEN), .AW(AW)) loader (
    .clk_i            (clock),
    .rst_ni           (reset),
    .en_i             (system_state == LOADING),
    .mem_write_o      (ld_write_s),
    .mem_addr_o       (ld_addr_s),
    .mem_write_data_o (ld_data_s),
    .last_o           (ld_last_s)
  );

  system_cpu #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) cpu (
    .clk_i            (clock),
    .rst_ni           (reset),
    .run_i            (system_state == EXECUTING),
    .mem_rdata_i      (mem_rdata_s),
    .mem_write_o      (cpu_write_s),
    .mem_addr_o       (cpu_addr_s),
    .mem_write_data_o (cpu_data_s)
  );

  system_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) ram (
    .clk_i   (clock),
    .we_i    (mem_write),
    .addr_i  (mem_addr),
    .wdata_i (mem_write_data),
    .rdata_o (mem_rdata_s)
  );

  // RAM port ownership: loader while loading, CPU while executing
  always_comb begin
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = 16'h0000;
    if (system_state == LOADING) begin
      mem_write      = ld_write_s;
      mem_addr       = ld_addr_s;
      mem_write_data = ld_data_s;
    end else if (system_state == EXECUTING) begin
      mem_write      = cpu_write_s;
      mem_addr       = cpu_addr_s;
      mem_write_data = cpu_data_s;
    end else begin
      mem_write      = 1'b0;
    end
  end

  // System sequencing; start only matters in IDLE
  always_comb begin
    system_state_d = system_state;
    case (system_state)
      IDLE: begin
        if (start) system_state_d = LOADING;
        else       system_state_d = IDLE;
      end
      LOADING: begin
        if (ld_last_s) system_state_d = EXECUTING;
        else           system_state_d = LOADING;
      end
      EXECUTING: system_state_d = EXECUTING;
      default:   system_state_d = IDLE;
    endcase
  end

  // System state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) system_state <= IDLE;
    else        system_state <= system_state_d;
  end
endmodule

// File: tb/tb_system.sv
// Bench for system: randomized start/reset timing against an ISA-level model.
module tb_system;
  localparam int MEM_DEPTH = 256;
  localparam int PROG_LEN  = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;

  system #(.MEM_DEPTH(MEM_DEPTH), .PROG_LEN(PROG_LEN)) dut (
    .clock (clock),
    .reset (reset),
    .start (start)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] image [0:PROG_LEN-1] = '{16'h7205, 16'h7407, 16'h1650, 16'h2888,
                                        16'h9610, 16'h8A10, 16'h0000};

  // reference model results
  logic [15:0] m_regs [0:7];
  logic [15:0] m_mem  [0:MEM_DEPTH-1];
  int          m_pc_after [$];
  int          m_st_addr  [$];
  logic [15:0] m_st_data  [$];
  int          m_halt_pc;

  // observed RAM writes
  int          w_addr [$];
  logic [15:0] w_data [$];
  bit          w_exec [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int wrap(input int x);
    return ((x % MEM_DEPTH) + MEM_DEPTH) % MEM_DEPTH;
  endfunction

  // Instruction-by-instruction interpretation of the image
  function automatic void run_model();
    int pc, npc, sxi, ea;
    logic [15:0] ir;
    logic [2:0] rd, s1, s2;
    for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 16'h0000;
    for (int i = 0; i < PROG_LEN; i++) m_mem[i] = image[i];
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    pc = 0;
    for (int step = 0; step < 200; step++) begin
      ir = m_mem[pc];
      if (ir[15:12] == 4'h0) break;
      rd = ir[11:9]; s1 = ir[8:6]; s2 = ir[5:3];
      sxi = int'(ir[5:0]);
      if (sxi >= 32) sxi = sxi - 64;
      ea  = wrap(int'(m_regs[s1]) + sxi);
      npc = wrap(pc + 1);
      case (ir[15:12])
        4'h1: m_regs[rd] = m_regs[s1] + m_regs[s2];
        4'h2: m_regs[rd] = m_regs[s1] - m_regs[s2];
        4'h3: m_regs[rd] = m_regs[s1] & m_regs[s2];
        4'h4: m_regs[rd] = m_regs[s1] | m_regs[s2];
        4'h5: m_regs[rd] = m_regs[s1] ^ m_regs[s2];
        4'h6: m_regs[rd] = m_regs[s1] + 16'(sxi);
        4'h7: m_regs[rd] = 16'(int'(ir[8:0]));
        4'h8: m_regs[rd] = m_mem[ea];
        4'h9: begin
          m_mem[ea] = m_regs[rd];
          m_st_addr.push_back(ea);
          m_st_data.push_back(m_regs[rd]);
        end
        4'hA: if (m_regs[rd] == m_regs[s1]) npc = wrap(pc + 1 + sxi);
        4'hB: npc = wrap(int'(ir[11:0]));
        default: ;
      endcase
      m_pc_after.push_back(npc);
      pc = npc;
    end
    m_halt_pc = pc;
  endfunction

  // Log any RAM write about to happen, then advance one clock
  task automatic cycle();
    if (dut.mem_write === 1'b1) begin
      w_addr.push_back(int'(dut.mem_addr));
      w_data.push_back(dut.mem_write_data);
      w_exec.push_back(32'(dut.system_state) == 32'd2);
    end
    @(negedge clock);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_sys"}, 32'(dut.system_state), 32'd0);
    chk({tag, "_pc"}, 32'(dut.cpu.program_counter), 32'd0);
    chk({tag, "_cst"}, 32'(dut.cpu.state), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", tag, i), 32'(dut.cpu.regs.regs[i]), 32'd0);
  endtask

  task automatic chk_final(input string tag);
    chk({tag, "_sys"}, 32'(dut.system_state), 32'd2);
    chk({tag, "_cst"}, 32'(dut.cpu.state), 32'd0);
    chk({tag, "_pc"}, 32'(dut.cpu.program_counter), 32'(m_halt_pc));
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", tag, i), 32'(dut.cpu.regs.regs[i]), 32'(m_regs[i]));
    for (int i = 0; i < m_st_addr.size(); i++)
      chk($sformatf("%s_mem%0h", tag, m_st_addr[i]), 32'(dut.ram.memory[m_st_addr[i]]), 32'(m_mem[m_st_addr[i]]));
  endtask

  task automatic chk_writes(input string tag);
    int n_exp;
    n_exp = PROG_LEN + m_st_addr.size();
    chk({tag, "_nwr"}, 32'(w_addr.size()), 32'(n_exp));
    for (int k = 0; k < w_addr.size() && k < n_exp; k++) begin
      if (k < PROG_LEN) begin
        chk($sformatf("%s_ld%0d_a", tag, k), 32'(w_addr[k]), 32'(k));
        chk($sformatf("%s_ld%0d_d", tag, k), 32'(w_data[k]), 32'(image[k]));
        chk($sformatf("%s_ld%0d_x", tag, k), 32'(w_exec[k]), 32'd0);
      end else begin
        chk($sformatf("%s_st%0d_a", tag, k), 32'(w_addr[k]), 32'(m_st_addr[k-PROG_LEN]));
        chk($sformatf("%s_st%0d_d", tag, k), 32'(w_data[k]), 32'(m_st_data[k-PROG_LEN]));
        chk($sformatf("%s_st%0d_x", tag, k), 32'(w_exec[k]), 32'd1);
      end
    end
  endtask

  initial begin
    int  total, abort_at, idx;
    bit  abort;
    run_model();
    total = PROG_LEN + 3 * m_pc_after.size();

    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_cleared("rst_hold");
    reset = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk_cleared("no_start");
    chk("no_start_nwr", 32'(w_addr.size()), 32'd0);

    for (int it = 0; it < 8; it++) begin
      abort = (it % 2 == 1) && (it != 7);
      reset = 1'b0;
      @(negedge clock);
      chk_cleared("rst_run");
      reset = 1'b1;
      repeat ($urandom_range(0, 5)) cycle();
      chk("idle_sys", 32'(dut.system_state), 32'd0);
      w_addr.delete(); w_data.delete(); w_exec.delete();

      start = 1'b1;
      cycle();
      start = 1'b0;
      chk("loading_sys", 32'(dut.system_state), 32'd1);
      abort_at = $urandom_range(1, total - 1);
      for (int t = 1; t <= total; t++) begin
        start = ($urandom_range(0, 5) == 0);
        cycle();
        if (abort && t == abort_at) begin
          start = 1'b0;
          reset = 1'b0;
          #1;
          chk_cleared("abort");
          break;
        end
        if (t == PROG_LEN - 1) chk("load_sys", 32'(dut.system_state), 32'd1);
        if (t == PROG_LEN)     chk("exec_sys", 32'(dut.system_state), 32'd2);
        if (t > PROG_LEN && (t - PROG_LEN) % 3 == 0) begin
          idx = (t - PROG_LEN) / 3 - 1;
          chk($sformatf("ins%0d_pc", idx), 32'(dut.cpu.program_counter), 32'(m_pc_after[idx]));
          chk($sformatf("ins%0d_cst", idx), 32'(dut.cpu.state), 32'd0);
        end
      end
      start = 1'b0;

      if (!abort) begin
        chk_final("run");
        chk_writes("run");
        for (int j = 0; j < 3; j++) begin
          repeat ($urandom_range(1, 4)) cycle();
          start = 1'b1;
          cycle();
          start = 1'b0;
        end
        repeat (4) cycle();
        chk_final("late_start");
        chk_writes("late_start");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
